// File: rtl/load_store_unit.sv
// Load/store unit between the datapath and a 64-bit data memory.
// Sub-doubleword stores use read-modify-write. Misaligned or illegal requests fault without memory traffic.
module load_store_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] rdata,
    output logic        misaligned,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    function automatic logic [63:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] d, input logic [2:0] off,
                                                input logic [2:0] f3);
        logic [63:0] sh;
        sh = d >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{56{sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{48{sh[15]}}, sh[15:0]};
            3'b010:  load_extend = {{32{sh[31]}}, sh[31:0]};
            3'b011:  load_extend = sh;
            3'b100:  load_extend = {56'h0, sh[7:0]};
            3'b101:  load_extend = {48'h0, sh[15:0]};
            3'b110:  load_extend = {32'h0, sh[31:0]};
            default: load_extend = 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] d, input logic [63:0] wd,
                                                input logic [2:0] off, input logic [1:0] sz);
        logic [63:0] m;
        m = lane_mask(sz) << {off, 3'b000};
        store_merge = (d & ~m) | ((wd << {off, 3'b000}) & m);
    endfunction

    state_t      state_r, next_s;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [2:0]  off_r;
    logic [63:0] wdata_r;
    logic [2:0]  cnt_r;
    logic        fault_s;
    logic        mis_s;
    logic        busy_r, done_r, mis_r, mem_wr_r;
    logic [63:0] rdata_r, mem_addr_r, mem_wdata_r;

    // Fault decode on the live request: alignment per size, plus illegal encodings
    always_comb begin
        mis_s = 1'b0;
        case (funct3[1:0])
            2'b01:   mis_s = addr[0];
            2'b10:   mis_s = (addr[1:0] != 2'b00);
            2'b11:   mis_s = (addr[2:0] != 3'b000);
            default: mis_s = 1'b0;
        endcase
        fault_s = mis_s | (funct3 == 3'b111) | (we & funct3[2]);
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req) begin
                    next_s = IDLE;
                end else if (fault_s) begin
                    next_s = DONE;
                end else if (we && (funct3[1:0] == 2'b11)) begin
                    next_s = WRITE;
                end else begin
                    next_s = READ;
                end
            end
            READ: begin
                if (cnt_r == LAT) begin
                    next_s = we_r ? WRITE : DONE;
                end else begin
                    next_s = READ;
                end
            end
            WRITE:   next_s = DONE;
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State, captured request, latency counter and registered outputs
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            funct3_r    <= 3'b000;
            off_r       <= 3'b000;
            wdata_r     <= 64'h0;
            cnt_r       <= 3'b000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mis_r       <= 1'b0;
            mem_wr_r    <= 1'b0;
            rdata_r     <= 64'h0;
            mem_addr_r  <= 64'h0;
            mem_wdata_r <= 64'h0;
        end else begin
            state_r  <= next_s;
            busy_r   <= (next_s != IDLE);
            done_r   <= (next_s == DONE);
            mem_wr_r <= (next_s == WRITE);
            mis_r    <= (state_r == IDLE) && req && fault_s;
            if (state_r == IDLE && req) begin
                we_r        <= we;
                funct3_r    <= funct3;
                off_r       <= addr[2:0];
                wdata_r     <= wdata;
                mem_addr_r  <= {addr[63:3], 3'b000};
                mem_wdata_r <= wdata;
            end
            // Counter restarts on every entry into READ so the sample point is relative to entry
            if (next_s == READ && state_r != READ) begin
                cnt_r <= 3'b000;
            end else if (state_r == READ) begin
                cnt_r <= cnt_r + 3'b001;
            end
            if (state_r == READ && cnt_r == LAT) begin
                if (we_r) begin
                    mem_wdata_r <= store_merge(mem_rdata, wdata_r, off_r, funct3_r[1:0]);
                end else begin
                    rdata_r <= load_extend(mem_rdata, off_r, funct3_r);
                end
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign misaligned = mis_r;
    assign mem_wr     = mem_wr_r;
    assign rdata      = rdata_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (latency 1 and 3), each with its own memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        Reset, req1, req3, we;
    logic [2:0]  funct3;
    logic [63:0] addr, wdata;
    logic        busy1, done1, mis1, mwr1, busy3, done3, mis3, mwr3;
    logic [63:0] rdata1, maddr1, mwdata1, mrdata1, rdata3, maddr3, mwdata3, mrdata3;
    logic [63:0] p0, p1;
    int cyc = 0;
    int start_cyc = 0;
    int checks = 0;
    int fails = 0;
    int wr_seen = 0;
    int wr_base;

    logic [63:0] mem1 [8] = '{64'h0, 64'h0, 64'h8877665544332211, 64'h0,
                              64'h0, 64'h0, 64'h0, 64'h0};
    logic [63:0] mem3 [8] = '{64'h0, 64'h0, 64'h8877665544332211, 64'h0,
                              64'h0, 64'h0, 64'h0, 64'h0};

    typedef struct { int lat; logic [63:0] rd; logic mis; } exp_t;
    typedef struct { int c; logic [63:0] a; logic [63:0] d; } wr_t;
    exp_t q1[$];
    exp_t q3[$];
    wr_t  wq[$];

    load_store_unit #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .Reset(Reset), .req(req1), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy1), .done(done1), .rdata(rdata1), .misaligned(mis1),
        .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_wr(mwr1), .mem_rdata(mrdata1));

    load_store_unit #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .Reset(Reset), .req(req3), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy3), .done(done3), .rdata(rdata3), .misaligned(mis3),
        .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_wr(mwr3), .mem_rdata(mrdata3));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mwr1) mem1[maddr1[5:3]] <= mwdata1;
        mrdata1 <= mem1[maddr1[5:3]];
        p0      <= mem3[maddr3[5:3]];
        p1      <= p0;
        mrdata3 <= p1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the latency-1 instance: completions and memory writes
    always @(negedge clk) begin : mon1
        exp_t e;
        wr_t  w;
        if (done1) begin
            if (q1.size() == 0) chk("unexpected_done1", {63'h0, done1}, 64'h0);
            else begin
                e = q1.pop_front();
                chk("done1_cycle", 64'(cyc - start_cyc), 64'(e.lat));
                chk("rdata1", rdata1, e.rd);
                chk("misaligned1", {63'h0, mis1}, {63'h0, e.mis});
            end
        end
        if (mwr1) begin
            wr_seen++;
            if (wq.size() == 0) chk("unexpected_write", {63'h0, mwr1}, 64'h0);
            else begin
                w = wq.pop_front();
                chk("write_cycle", 64'(cyc - start_cyc), 64'(w.c));
                chk("write_addr", maddr1, w.a);
                chk("write_data", mwdata1, w.d);
            end
        end
    end

    // Monitor for the latency-3 instance, which only ever performs loads
    always @(negedge clk) begin : mon3
        exp_t e;
        if (done3) begin
            if (q3.size() == 0) chk("unexpected_done3", {63'h0, done3}, 64'h0);
            else begin
                e = q3.pop_front();
                chk("done3_cycle", 64'(cyc - start_cyc), 64'(e.lat));
                chk("rdata3", rdata3, e.rd);
                chk("misaligned3", {63'h0, mis3}, {63'h0, e.mis});
            end
        end
        if (mwr3) chk("unexpected_write3", {63'h0, mwr3}, 64'h0);
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy1 || busy3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            fails++;
            $display("FAIL idle_timeout: busy still high after %0d cycles", n);
        end
    endtask

    task automatic issue(input bit use3, input logic w, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] d, input int lat, input logic [63:0] rd, input logic mis);
        exp_t e;
        e.lat = lat;
        e.rd  = rd;
        e.mis = mis;
        if (use3) q3.push_back(e);
        else q1.push_back(e);
        we = w; funct3 = f; addr = a; wdata = d;
        start_cyc = cyc;
        if (use3) req3 = 1'b1;
        else req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        req3 = 1'b0;
        wait_idle();
    endtask

    task automatic push_write(input int c, input logic [63:0] a, input logic [63:0] d);
        wr_t w;
        w.c = c;
        w.a = a;
        w.d = d;
        wq.push_back(w);
    endtask

    initial begin
        Reset = 1'b1; req1 = 1'b1; req3 = 1'b1; we = 1'b0;
        funct3 = 3'b000; addr = 64'h17; wdata = 64'h0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_busy", {63'h0, busy1}, 64'h0);
            chk("reset_done", {63'h0, done1}, 64'h0);
            chk("reset_mem_wr", {63'h0, mwr1}, 64'h0);
            chk("reset_rdata", rdata1, 64'h0);
            chk("reset_busy3", {63'h0, busy3}, 64'h0);
        end
        Reset = 1'b0; req1 = 1'b0; req3 = 1'b0;
        @(negedge clk);

        issue(0, 1'b0, 3'b000, 64'h17, 64'h0, 3, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
        issue(0, 1'b0, 3'b100, 64'h17, 64'h0, 3, 64'h0000_0000_0000_0088, 1'b0);
        issue(0, 1'b0, 3'b010, 64'h14, 64'h0, 3, 64'hFFFF_FFFF_8877_6655, 1'b0);
        issue(1, 1'b0, 3'b010, 64'h14, 64'h0, 5, 64'hFFFF_FFFF_8877_6655, 1'b0);

        // Reset while the byte store is in its read phase
        we = 1'b1; funct3 = 3'b000; addr = 64'h13; wdata = 64'h99;
        start_cyc = cyc;
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("midrst_busy", {63'h0, busy1}, 64'h0);
        chk("midrst_done", {63'h0, done1}, 64'h0);
        chk("midrst_mem_wr", {63'h0, mwr1}, 64'h0);
        chk("midrst_mem_addr", maddr1, 64'h0);
        chk("midrst_rdata", rdata1, 64'h0);
        wr_base = wr_seen;
        repeat (10) @(negedge clk);
        chk("midrst_write_count", 64'(wr_seen - wr_base), 64'h0);
        chk("midrst_mem_intact", mem1[2], 64'h8877_6655_4433_2211);
        issue(0, 1'b0, 3'b000, 64'h13, 64'h0, 3, 64'h0000_0000_0000_0044, 1'b0);

        push_write(3, 64'h10, 64'h8877_6655_ABCD_2211);
        issue(0, 1'b1, 3'b001, 64'h12, 64'h0000_0000_0000_ABCD, 4, 64'h44, 1'b0);
        issue(0, 1'b0, 3'b001, 64'h12, 64'h0, 3, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0);

        push_write(1, 64'h20, 64'h0123_4567_89AB_CDEF);
        issue(0, 1'b1, 3'b011, 64'h20, 64'h0123_4567_89AB_CDEF, 2, 64'hFFFF_FFFF_FFFF_ABCD, 1'b0);
        issue(0, 1'b0, 3'b011, 64'h20, 64'h0, 3, 64'h0123_4567_89AB_CDEF, 1'b0);

        issue(0, 1'b0, 3'b010, 64'h16, 64'h0, 1, 64'h0123_4567_89AB_CDEF, 1'b1);
        issue(0, 1'b1, 3'b010, 64'h16, 64'h5555, 1, 64'h0123_4567_89AB_CDEF, 1'b1);
        issue(0, 1'b0, 3'b111, 64'h10, 64'h0, 1, 64'h0123_4567_89AB_CDEF, 1'b1);
        issue(0, 1'b1, 3'b100, 64'h10, 64'h77, 1, 64'h0123_4567_89AB_CDEF, 1'b1);

        chk("mem_after_sh", mem1[2], 64'h8877_6655_ABCD_2211);
        chk("pending_q1", 64'(q1.size()), 64'h0);
        chk("pending_q3", 64'(q3.size()), 64'h0);
        chk("pending_writes", 64'(wq.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
